psum_accumulator_pool: RTL
==========================

Name: psum_accumulator_pool

Overview:
Parametrised channel accumulator placed below one column of the systolic array. It sums signed partial sums for every output pixel across all input channels in an internal dual-port SRAM. It then requantises each sum (arithmetic shift plus saturation) and streams the results to the activation stage, either as raw conv output or as 2x2/stride-2 max-pooled output, with full valid/ready backpressure.

Parameters:
PSUM_W, 16, width of signed partial sum input
ACC_W, 32, width of signed accumulator word stored in SRAM
OUT_W, 8, width of signed output sample
DEPTH, 1024, accumulator SRAM words; AW = $clog2(DEPTH)
SIZE_W, 6, width of ofmap_size_i
CH_W, 8, width of ifmap_ch_i

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
psum_i  in  PSUM_W  signed partial sum, raster order per channel
pvalid_i  in  1  psum_i valid
pready_o  out  1  accumulator can accept psum_i
ofmap_size_i  in  SIZE_W  ofmap side N; N*N <= DEPTH; sampled at frame start
ifmap_ch_i  in  CH_W  input channel count C; sampled at frame start
pool_en_i  in  1  1 = 2x2 max-pool output, 0 = raw conv output; sampled at frame start
shift_i  in  5  requantisation arithmetic right shift; sampled at frame start
out_valid_o  out  1  output sample valid
out_ready_i  in  1  downstream accepts sample
out_data_o  out  OUT_W  signed requantised sample
out_addr_o  out  AW  output index, 0-based raster order
out_last_o  out  1  marks final sample of frame, qualified by out_valid_o
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; pready_o=1, out_valid_o=0, out_last_o=0, out_data_o=0, out_addr_o=0, busy_o=0; all counters 0. Reset mid-frame abandons the frame. SRAM contents are not cleared; the channel-0 rule makes them irrelevant.
- Transfer: a psum transfer occurs on pvalid_i && pready_o. An output transfer occurs on out_valid_o && out_ready_i.
- States: IDLE -> ACC -> DRAIN -> OUT -> IDLE.
- IDLE:
  - pready_o=1.
  - The first transfer latches N, C, pool_en, shift. N=0 is treated as 1; C=0 is treated as 1.
  - The same transfer is accumulated as pixel 0, channel 0. Go to ACC.
- ACC:
  - pready_o=1. Pixel counter p runs 0..N*N-1, then wraps; on wrap the channel counter c increments.
  - Each transfer reads SRAM[p]. One cycle later it writes SRAM[p] = (c==0 ? 0 : SRAM[p]) + sign-extended psum, modulo 2^ACC_W, with no saturation during accumulation.
  - Read-after-write hazard (e.g. N=1, back-to-back transfers): if the read address equals the address being written in the same cycle, the adder result is forwarded. No stall is allowed.
  - After the transfer for p=N*N-1, c=C-1, go to DRAIN.
- DRAIN: pready_o=0. Wait for the final write to commit (1 cycle), then go to OUT.
- Requantisation: v = sum >>> shift (arithmetic), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- OUT, conv mode:
  - Emits N*N samples; out_addr_o = p.
  - The first out_valid_o is asserted at most 3 cycles after entering OUT.
  - Sustains 1 sample/cycle while out_ready_i=1.
- OUT, pool mode:
  - Emits floor(N/2)^2 samples. Each is the max of the requantised values at (2r,2k), (2r,2k+1), (2r+1,2k), (2r+1,2k+1).
  - Odd N: the last row and column are dropped. N=1 in pool mode emits zero samples and returns to IDLE without asserting out_valid_o.
  - Throughput is at least 1 sample per 4 cycles.
- Backpressure: while out_valid_o=1 && out_ready_i=0, out_data_o, out_addr_o and out_last_o hold stable. out_valid_o never drops without a transfer.
- out_last_o is asserted with the final sample. After that sample's transfer, the block returns to IDLE the next cycle.
- pvalid_i asserted while pready_o=0 is ignored and causes no state change.

Optional Feature:
Macro ACC_RELU_EN.
- Defined: after requantisation, negative values are clamped to 0, before pooling and output.
- Undefined: signed values pass through unchanged.

Test Plan:
1. Conv basics: N=2, C=1, pool_en=0, shift=0, psums 1,2,3,4 -> outputs 1,2,3,4 at addr 0..3; out_last_o on addr 3; busy_o=0 afterwards.
2. Saturation: N=2, C=3, shift=0, each channel psums 10,-5,100,127 -> sums 30,-15,300,381 -> outputs 30,-15,127,127. Negative check: C=2 with psums -100 -> sum -200 -> output -128.
3. Shift and forwarding: N=1, C=4, psum 100 on four consecutive cycles, shift=2 -> sum 400 -> single output 100 with out_last_o=1.
4. Pool: N=4, C=1, pool_en=1, psums 0..15 -> outputs 5,7,13,15 at addr 0..3, last on 15. With N=5 and psums 0..24 -> outputs 6,8,16,18.
5. Backpressure: scenario 1 with out_ready_i toggling 0,1,0,1,... -> identical sequence, data stable while stalled; pvalid_i pulses during OUT are ignored and pready_o=0.
6. Reset mid-frame: assert rst_n=0 during ACC of a C=2 frame, then run scenario 1 -> outputs exactly 1,2,3,4 with no residue. With ACC_RELU_EN defined, scenario 2 outputs 30,0,127,127.

Source files
------------

// File: rtl/psum_accumulator_pool.sv
// psum_accumulator_pool
// Channel accumulator placed below one systolic-array column. Partial sums for
// every output pixel are summed across input channels in an internal SRAM.
// Each sum is then requantised (arithmetic shift plus saturation) and streamed
// out, either as raw conv output or as 2x2/stride-2 max-pooled output.
// Optional build macro: ACC_RELU_EN. When defined, negative requantised values
// are clamped to zero before pooling and output.
module psum_accumulator_pool #(
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 1024,
  parameter int SIZE_W = 6,
  parameter int CH_W   = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [PSUM_W-1:0] psum_i,
  input  logic                     pvalid_i,
  output logic                     pready_o,
  input  logic [SIZE_W-1:0]        ofmap_size_i,
  input  logic [CH_W-1:0]          ifmap_ch_i,
  input  logic                     pool_en_i,
  input  logic [4:0]               shift_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [OUT_W-1:0]  out_data_o,
  output logic [AW-1:0]            out_addr_o,
  output logic                     out_last_o,
  output logic                     busy_o
);

  // Pixel-count width: wide enough for N*N and for any SRAM address.
  localparam int NN_W = (2 * SIZE_W > AW) ? 2 * SIZE_W : AW;

  localparam logic [SIZE_W-1:0] SZ_ONE = {{(SIZE_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0]   CH_ONE = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]     AW_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [NN_W-1:0]   NN_ONE = {{(NN_W-1){1'b0}}, 1'b1};

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_HI = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_LO = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Arithmetic shift, saturate to the output range, optional negative clamp.
  function automatic logic signed [OUT_W-1:0] requant(
    input logic signed [ACC_W-1:0] sum,
    input logic [4:0]              sh
  );
    logic signed [ACC_W-1:0] v;
    logic signed [OUT_W-1:0] r;
    logic signed [OUT_W-1:0] res;
    v = sum >>> sh;
    if (v > SAT_HI) begin
      r = OUT_HI;
    end else if (v < SAT_LO) begin
      r = OUT_LO;
    end else begin
      r = v[OUT_W-1:0];
    end
`ifdef ACC_RELU_EN
    if (r[OUT_W-1]) begin
      res = '0;
    end else begin
      res = r;
    end
`else
    res = r;
`endif
    return res;
  endfunction

  state_t state_r, state_nxt_s;

  // Frame configuration (latched on the first psum of a frame)
  logic [SIZE_W-1:0] n_r, n_in_s, half_r, half_in_s;
  logic [CH_W-1:0]   ch_num_r, ch_in_s, ch_cur_s;
  logic [NN_W-1:0]   nn_r, nn_in_s, nn_cur_s, total_r, total_in_s;
  logic              pool_r;
  logic [4:0]        shift_r;

  // Accumulation path
  logic              psum_xfer_s, last_pix_s, last_ch_s, frame_done_s;
  logic [AW-1:0]     p_r, pix_s;
  logic [CH_W-1:0]   c_r, chan_s;
  logic              wr_en_r, wr_clr_r;
  logic [AW-1:0]     wr_addr_r;
  logic signed [PSUM_W-1:0] wr_psum_r;
  logic signed [ACC_W-1:0]  acc_base_s, sum_s;

  // Shared SRAM read port
  logic signed [ACC_W-1:0] mem_r [DEPTH];
  logic                    rd_en_s;
  logic [AW-1:0]           rd_addr_s, pool_addr_s;
  logic signed [ACC_W-1:0] rd_data_r;

  // Output sequencer
  logic              more_r, issue_s;
  logic [AW-1:0]     ptr_r, pbase_r, out_idx_r;
  logic [SIZE_W-1:0] prow_r, pcol_r;
  logic [1:0]        psub_r;
  logic              s1_vld_r, s1_first_r, s1_last_r, s1_take_s, out_adv_s;
  logic signed [OUT_W-1:0] q_s, max_r, cand_s;

  // Current frame geometry: live inputs while idle, latched values otherwise.
  always_comb begin
    psum_xfer_s = pvalid_i && pready_o;
    n_in_s      = (ofmap_size_i == '0) ? SZ_ONE : ofmap_size_i;
    ch_in_s     = (ifmap_ch_i == '0) ? CH_ONE : ifmap_ch_i;
    half_in_s   = {1'b0, n_in_s[SIZE_W-1:1]};
    nn_in_s     = NN_W'(n_in_s) * NN_W'(n_in_s);
    total_in_s  = pool_en_i ? (NN_W'(half_in_s) * NN_W'(half_in_s)) : nn_in_s;
    if (state_r == ST_IDLE) begin
      nn_cur_s = nn_in_s;
      ch_cur_s = ch_in_s;
      pix_s    = '0;
      chan_s   = '0;
    end else begin
      nn_cur_s = nn_r;
      ch_cur_s = ch_num_r;
      pix_s    = p_r;
      chan_s   = c_r;
    end
    last_pix_s   = (NN_W'(pix_s) == (nn_cur_s - NN_ONE));
    last_ch_s    = (chan_s == (ch_cur_s - CH_ONE));
    frame_done_s = psum_xfer_s && last_pix_s && last_ch_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (psum_xfer_s) begin
          state_nxt_s = frame_done_s ? ST_DRAIN : ST_ACC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (frame_done_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_DRAIN: begin
        if (total_r == '0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_valid_o && out_ready_i && out_last_o) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; pready/busy are registered from the next state so they match it exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pready_o <= 1'b1;
      busy_o   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pready_o <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACC);
      busy_o   <= (state_nxt_s != ST_IDLE);
    end
  end

  // Latch frame geometry and requantisation settings on the first psum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_r      <= '0;
      half_r   <= '0;
      ch_num_r <= '0;
      nn_r     <= '0;
      total_r  <= '0;
      pool_r   <= 1'b0;
      shift_r  <= '0;
    end else if ((state_r == ST_IDLE) && psum_xfer_s) begin
      n_r      <= n_in_s;
      half_r   <= half_in_s;
      ch_num_r <= ch_in_s;
      nn_r     <= nn_in_s;
      total_r  <= total_in_s;
      pool_r   <= pool_en_i;
      shift_r  <= shift_i;
    end
  end

  // Pixel/channel counters advance on every accepted psum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_r <= '0;
      c_r <= '0;
    end else if (psum_xfer_s) begin
      p_r <= last_pix_s ? '0 : (pix_s + AW_ONE);
      c_r <= last_pix_s ? (chan_s + CH_ONE) : chan_s;
    end
  end

  // Write stage: carries the accepted psum one cycle to meet its SRAM read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_clr_r  <= 1'b0;
      wr_addr_r <= '0;
      wr_psum_r <= '0;
    end else begin
      wr_en_r   <= psum_xfer_s;
      wr_clr_r  <= (chan_s == '0);
      wr_addr_r <= pix_s;
      wr_psum_r <= psum_i;
    end
  end

  // Channel 0 starts from zero so stale SRAM contents never leak into a frame.
  always_comb begin
    if (wr_clr_r) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = rd_data_r;
    end
    sum_s = acc_base_s + {{(ACC_W-PSUM_W){wr_psum_r[PSUM_W-1]}}, wr_psum_r};
  end

  // Read address mux: accumulation reads win, otherwise the output sequencer.
  always_comb begin
    pool_addr_s = pbase_r + (psub_r[1] ? AW'(n_r) : '0) + AW'({pcol_r, 1'b0}) + AW'(psub_r[0]);
    rd_en_s     = psum_xfer_s || issue_s;
    if (psum_xfer_s) begin
      rd_addr_s = pix_s;
    end else if (pool_r) begin
      rd_addr_s = pool_addr_s;
    end else begin
      rd_addr_s = ptr_r;
    end
  end

  // SRAM write port.
  always_ff @(posedge clk) begin
    if (wr_en_r) begin
      mem_r[wr_addr_r] <= sum_s;
    end
  end

  // SRAM read port; a read of the word being written this cycle takes the adder result.
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      if (wr_en_r && (wr_addr_r == rd_addr_s)) begin
        rd_data_r <= sum_s;
      end else begin
        rd_data_r <= mem_r[rd_addr_s];
      end
    end
  end

  // Output pipeline handshake and running max of the current pool window.
  always_comb begin
    out_adv_s = !out_valid_o || out_ready_i;
    s1_take_s = s1_vld_r && (!s1_last_r || out_adv_s);
    issue_s   = (state_r == ST_OUT) && more_r && (!s1_vld_r || s1_take_s);
    q_s       = requant(rd_data_r, shift_r);
    if (s1_first_r || (q_s > max_r)) begin
      cand_s = q_s;
    end else begin
      cand_s = max_r;
    end
  end

  // Output read sequencer: linear in conv mode, 4 reads per window in pool mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      more_r     <= 1'b0;
      ptr_r      <= '0;
      pbase_r    <= '0;
      prow_r     <= '0;
      pcol_r     <= '0;
      psub_r     <= 2'd0;
      s1_vld_r   <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      max_r      <= '0;
      out_idx_r  <= '0;
    end else if (state_r == ST_DRAIN) begin
      more_r    <= (total_r != '0);
      ptr_r     <= '0;
      pbase_r   <= '0;
      prow_r    <= '0;
      pcol_r    <= '0;
      psub_r    <= 2'd0;
      s1_vld_r  <= 1'b0;
      out_idx_r <= '0;
    end else begin
      if (issue_s) begin
        s1_vld_r   <= 1'b1;
        s1_first_r <= !pool_r || (psub_r == 2'd0);
        s1_last_r  <= !pool_r || (psub_r == 2'd3);
        if (pool_r) begin
          psub_r <= psub_r + 2'd1;
          if (psub_r == 2'd3) begin
            if (pcol_r == (half_r - SZ_ONE)) begin
              pcol_r  <= '0;
              prow_r  <= prow_r + SZ_ONE;
              pbase_r <= pbase_r + AW'({n_r, 1'b0});
              if (prow_r == (half_r - SZ_ONE)) begin
                more_r <= 1'b0;
              end
            end else begin
              pcol_r <= pcol_r + SZ_ONE;
            end
          end
        end else begin
          ptr_r <= ptr_r + AW_ONE;
          if (NN_W'(ptr_r) == (nn_r - NN_ONE)) begin
            more_r <= 1'b0;
          end
        end
      end else if (s1_take_s) begin
        s1_vld_r <= 1'b0;
      end
      if (s1_take_s && !s1_last_r) begin
        max_r <= cand_s;
      end
      if (s1_take_s && s1_last_r) begin
        out_idx_r <= out_idx_r + AW_ONE;
      end
    end
  end

  // Output register: loads a finished sample, holds it until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_data_o  <= '0;
      out_addr_o  <= '0;
    end else if (state_r != ST_OUT) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end else if (s1_take_s && s1_last_r) begin
      out_valid_o <= 1'b1;
      out_data_o  <= cand_s;
      out_addr_o  <= out_idx_r;
      out_last_o  <= (NN_W'(out_idx_r) == (total_r - NN_ONE));
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end
  end

endmodule
